// File: rtl/mem_map_pkg.sv
// Shared types and elaboration-time helpers for the memory-map controller.
// Contents: controller state enum, address-region enum, Fibonacci ROM word
// generator and the bank-index decoder.
package mem_map_pkg;

    typedef enum logic [0:0] {IDLE, CLEAR} state_e;

    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_UNMAPPED} region_e;

    // F(index) mod 2^width with F(0) = F(1) = 1; width is at most 32.
    function automatic logic [31:0] fib_word(input int unsigned index,
                                             input int unsigned width);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] t;
        logic [63:0] mask;
        mask = (width >= 32) ? 64'hFFFF_FFFF : ((64'd1 << width) - 64'd1);
        a = 64'd1;
        b = 64'd1;
        for (int unsigned i = 1; i < index; i++) begin
            t = (a + b) & mask;
            a = b;
            b = t;
        end
        return 32'(b & mask);
    endfunction

    // ROM banks sit at the bottom of the bank space, RAM banks directly above.
    function automatic region_e bank_region(input int unsigned bank,
                                            input int unsigned rom_banks,
                                            input int unsigned ram_banks);
        if (bank < rom_banks) begin
            return REG_ROM;
        end
        if (bank < rom_banks + ram_banks) begin
            return REG_RAM;
        end
        return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/mem_map_ram_bank.sv
// One RAM bank of the memory map: synchronous write, combinational read.
// Ports: clk (clock), we (write enable), offset (word offset),
//        wdata (write data), rdata (read data at offset, combinational).
// Contents are not reset.
module mem_map_ram_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OFF_W  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**OFF_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[offset] <= wdata;
        end
    end

    assign rdata = mem[offset];

endmodule

// File: rtl/mem_map_ctrl.sv
// Memory-map controller: single request/response port over a banked space of
// Fibonacci ROM banks, RAM banks and unmapped banks, with a RAM-clear sequencer.
// Ports: clk, rst (async, active-high); req/we/addr/wdata request inputs;
//        ready (combinational, high in IDLE); resp_valid/resp_err/rdata
//        registered one-cycle response; clear_start request, clear_done pulse.
module mem_map_ctrl
    import mem_map_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OFF_W     = 3,
    parameter int unsigned SEL_W     = 5,
    parameter int unsigned ROM_BANKS = 8,
    parameter int unsigned RAM_BANKS = 8,
    localparam int unsigned ADDR_W   = SEL_W + OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] rdata,
    input  logic              clear_start,
    output logic              clear_done
);

    localparam int unsigned DEPTH     = 2**OFF_W;
    localparam int unsigned ROM_WORDS = ROM_BANKS * DEPTH;

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              clear_done_d;
    logic              resp_valid_d, resp_err_d;
    logic [DATA_W-1:0] rdata_d;

    logic [SEL_W-1:0]  bank_sel;
    logic [OFF_W-1:0]  offset;
    region_e           region;
    logic              accept;
    logic              clearing;
    logic [DATA_W-1:0] rom_word;
    logic [DATA_W-1:0] ram_word;

    logic [DATA_W-1:0] rom       [ROM_WORDS];
    logic [DATA_W-1:0] ram_rdata [RAM_BANKS];

    assign bank_sel = addr[ADDR_W-1:OFF_W];
    assign offset   = addr[OFF_W-1:0];
    assign region   = bank_region(32'(bank_sel), ROM_BANKS, RAM_BANKS);
    assign ready    = (state_q == IDLE);
    assign accept   = req && ready;
    assign clearing = (state_q == CLEAR);

    // Constant table; synthesis folds it into logic.
    for (genvar i = 0; i < ROM_WORDS; i++) begin : g_rom
        assign rom[i] = DATA_W'(fib_word(i, DATA_W));
    end

    // While clearing, every bank is written with zero at the sequencer offset.
    for (genvar i = 0; i < RAM_BANKS; i++) begin : g_ram
        logic bank_we;
        assign bank_we = clearing || (accept && we && (bank_sel == SEL_W'(ROM_BANKS + i)));

        mem_map_ram_bank #(
            .DATA_W(DATA_W),
            .OFF_W (OFF_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .offset(clearing ? clr_cnt_q : offset),
            .wdata (clearing ? '0 : wdata),
            .rdata (ram_rdata[i])
        );
    end

    always_comb begin
        rom_word = '0;
        for (int unsigned i = 0; i < ROM_WORDS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rom_word = rom[i];
            end
        end
        ram_word = '0;
        for (int unsigned i = 0; i < RAM_BANKS; i++) begin
            if (bank_sel == SEL_W'(ROM_BANKS + i)) begin
                ram_word = ram_rdata[i];
            end
        end
    end

    // Response for the request accepted at the coming edge.
    always_comb begin
        resp_valid_d = accept;
        resp_err_d   = 1'b0;
        rdata_d      = '0;
        if (accept) begin
            case (region)
                REG_ROM: begin
                    if (we) begin
                        resp_err_d = 1'b1;
                    end else begin
                        rdata_d = rom_word;
                    end
                end
                REG_RAM: begin
                    if (!we) begin
                        rdata_d = ram_word;
                    end
                end
                default: resp_err_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clear_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == OFF_W'(DEPTH - 1)) begin
                    state_d      = IDLE;
                    clr_cnt_d    = '0;
                    clear_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            clear_done <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata      <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clear_done <= clear_done_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            rdata      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Self-checking bench for mem_map_ctrl (default parameters): directed scenarios
// with literal expectations plus randomized traffic against a behavioural model.
module tb_mem_map_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic       clear_start = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       ready, resp_valid, resp_err, clear_done;
    logic [7:0] rdata;

    mem_map_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .rdata      (rdata),
        .clear_start(clear_start),
        .clear_done (clear_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ROM table, RAM image, remaining clear cycles.
    logic [7:0] rom_m [64];
    logic [7:0] ram_m [64];
    int         clear_left = 0;
    bit         exp_valid = 1'b0, exp_err = 1'b0, exp_done = 1'b0;
    logic [7:0] exp_rdata = '0;

    initial begin
        rom_m[0] = 8'd1;
        rom_m[1] = 8'd1;
        for (int n = 2; n < 64; n++) rom_m[n] = rom_m[n-1] + rom_m[n-2];
        for (int n = 0; n < 64; n++) ram_m[n] = '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left <= 0;
            exp_valid  <= 1'b0;
            exp_err    <= 1'b0;
            exp_rdata  <= '0;
            exp_done   <= 1'b0;
        end else begin
            exp_valid <= 1'b0;
            exp_err   <= 1'b0;
            exp_rdata <= '0;
            exp_done  <= 1'b0;
            if (clear_left > 0) begin
                for (int b = 0; b < 8; b++) ram_m[b*8 + 8 - clear_left] <= '0;
                clear_left <= clear_left - 1;
                exp_done   <= (clear_left == 1);
            end else begin
                if (req) begin
                    exp_valid <= 1'b1;
                    if (addr < 8'h40) begin
                        if (we) exp_err <= 1'b1;
                        else exp_rdata <= rom_m[addr[5:0]];
                    end else if (addr < 8'h80) begin
                        if (we) ram_m[addr[5:0]] <= wdata;
                        else exp_rdata <= ram_m[addr[5:0]];
                    end else begin
                        exp_err <= 1'b1;
                    end
                end
                if (clear_start) clear_left <= 8;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            check("ready", 32'(ready), 32'(clear_left == 0));
            check("resp_valid", 32'(resp_valid), 32'(exp_valid));
            check("clear_done", 32'(clear_done), 32'(exp_done));
            if (exp_valid) begin
                check("resp_err", 32'(resp_err), 32'(exp_err));
                check("rdata", 32'(rdata), 32'(exp_rdata));
            end
        end
    end

    // Monitor for directed scenarios.
    bit         q_err [$];
    logic [7:0] q_rd  [$];
    int         done_cnt = 0, busy_cnt = 0, busy_resp = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                q_err.push_back(resp_err);
                q_rd.push_back(rdata);
            end
            if (clear_done) done_cnt++;
            if (!ready) busy_cnt++;
            if (!ready && resp_valid) busy_resp++;
        end
    end

    task automatic reset_mon();
        q_err.delete();
        q_rd.delete();
        done_cnt  = 0;
        busy_cnt  = 0;
        busy_resp = 0;
    endtask

    task automatic check_resp(input string name, input bit err, input logic [7:0] data);
        if (q_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no response expected err=%0d rdata=%0h", name, err, data);
        end else begin
            check({name, "_err"}, 32'(q_err.pop_front()), 32'(err));
            check({name, "_rdata"}, 32'(q_rd.pop_front()), 32'(data));
        end
    endtask

    task automatic op(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d,
                      input bit c);
        @(negedge clk);
        #1;
        req = r;
        we = w;
        addr = a;
        wdata = d;
        clear_start = c;
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_clear_done", 32'(clear_done), 32'd0);
        #1 rst = 1'b0;
        run_cmp = 1'b1;

        // ROM reads back-to-back.
        reset_mon();
        op(1, 0, 8'h05, 8'h00, 0);
        op(1, 0, 8'h0F, 8'h00, 0);
        idle(2);
        check("rom_b2b_count", q_rd.size(), 32'd2);
        check_resp("rom_05", 1'b0, 8'h08);
        check_resp("rom_0f", 1'b0, 8'hDB);

        // RAM write then read-after-write.
        reset_mon();
        op(1, 1, 8'h40, 8'hA5, 0);
        op(1, 0, 8'h40, 8'h00, 0);
        idle(2);
        check_resp("ram_wr_40", 1'b0, 8'h00);
        check_resp("ram_rd_40", 1'b0, 8'hA5);

        // ROM write error, ROM unchanged, unmapped access.
        reset_mon();
        op(1, 1, 8'h03, 8'hFF, 0);
        op(1, 0, 8'h03, 8'h00, 0);
        op(1, 0, 8'h80, 8'h00, 0);
        idle(2);
        check_resp("rom_wr_err", 1'b1, 8'h00);
        check_resp("rom_rd_03", 1'b0, 8'h03);
        check_resp("unmapped_80", 1'b1, 8'h00);

        // Full clear of RAM.
        reset_mon();
        op(1, 1, 8'h4F, 8'h3C, 0);
        op(1, 1, 8'h7F, 8'h11, 0);
        op(0, 0, 8'h00, 8'h00, 1);
        idle(12);
        check("clear_busy_cycles", busy_cnt, 32'd8);
        check("clear_done_pulses", done_cnt, 32'd1);
        reset_mon();
        op(1, 0, 8'h4F, 8'h00, 0);
        op(1, 0, 8'h7F, 8'h00, 0);
        op(1, 0, 8'h0A, 8'h00, 0);
        idle(2);
        check_resp("cleared_4f", 1'b0, 8'h00);
        check_resp("cleared_7f", 1'b0, 8'h00);
        check_resp("rom_after_clear", 1'b0, 8'h59);

        // req held through a clear, second clear_start mid-clear.
        reset_mon();
        op(0, 0, 8'h00, 8'h00, 1);
        repeat (3) op(1, 0, 8'h05, 8'h00, 0);
        op(1, 0, 8'h05, 8'h00, 1);
        repeat (8) op(1, 0, 8'h05, 8'h00, 0);
        idle(3);
        check("hold_busy_cycles", busy_cnt, 32'd8);
        check("hold_done_pulses", done_cnt, 32'd1);
        check("hold_resp_in_clear", busy_resp, 32'd0);
        check("hold_resp_count", q_rd.size(), 32'd4);

        // Reset three cycles into a clear.
        reset_mon();
        op(0, 0, 8'h00, 8'h00, 1);
        idle(3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_resp_err", 32'(resp_err), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        check("mid_rst_clear_done", 32'(clear_done), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        idle(12);
        check("mid_rst_no_done", done_cnt, 32'd0);
        check("mid_rst_ready_after", 32'(ready), 32'd1);

        // Randomized traffic.
        repeat (1500) begin
            op(($urandom % 10) < 7, $urandom % 2, 8'($urandom_range(0, 8'h9F)),
               8'($urandom), ($urandom % 40) == 0);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_map_ctrl.md
# mem_map_ctrl

Parametrised memory-map controller that serves a single request/response port over a banked address space. The address space holds a block of read-only banks preloaded with a Fibonacci table, followed by a block of read/write RAM banks, with every other bank unmapped. It adds handshaking, registered responses, access-error reporting and a hardware RAM-clear sequencer. It sits between a bus master (CPU or testbench driver) and on-chip storage, and replaces ad-hoc per-design ROM/SRAM decoders.

## Interface
- DATA_W, 8: word width.
- OFF_W, 3: word-offset bits per bank (bank depth 2^OFF_W).
- SEL_W, 5: bank-select bits; ADDR_W = SEL_W + OFF_W.
- ROM_BANKS, 8: number of ROM banks, mapped at bank indices 0..ROM_BANKS-1.
- RAM_BANKS, 8: number of RAM banks, mapped at bank indices ROM_BANKS..ROM_BANKS+RAM_BANKS-1. Constraint: ROM_BANKS+RAM_BANKS <= 2^SEL_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  request valid.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  ADDR_W  {bank select, word offset}.
- wdata  in  DATA_W  write data.
- ready  out  1  controller can accept a request this cycle.
- resp_valid  out  1  one-cycle response pulse.
- resp_err  out  1  error flag; qualified by resp_valid.
- rdata  out  DATA_W  read data; qualified by resp_valid.
- clear_start  in  1  request to zero all RAM banks.
- clear_done  out  1  one-cycle pulse when a clear completes.

## Operation
- States: IDLE, CLEAR. Reset state is IDLE.
- Reset values: resp_valid=0, resp_err=0, rdata=0, clear_done=0, clear counter=0. ready=1, because it is combinational from the state (ready = state==IDLE).
- RAM contents are not reset.
- Accept condition: req && ready at a rising edge.
- Every accepted request produces exactly one resp_valid pulse.
- ROM bank b, word w holds F(b*2^OFF_W + w) mod 2^DATA_W, where F(0)=F(1)=1 and F(n)=F(n-1)+F(n-2). The table is fixed at elaboration.
- Read of a ROM or RAM bank: rdata = the stored word, resp_err=0.
- Write to a RAM bank: the word is updated at the accept edge. rdata=0, resp_err=0.
- Write to a ROM bank: no state change; resp_err=1, rdata=0.
- Any access to an unmapped bank: resp_err=1, rdata=0, no state change.
- clear_start sampled in IDLE moves the FSM to CLEAR. In CLEAR, one word offset is zeroed per cycle across all RAM banks in parallel, counter 0..2^OFF_W-1.
- After the last offset, the FSM returns to IDLE and clear_done pulses once.
- clear_start in CLEAR is ignored. ready=0 throughout CLEAR; req is ignored there and no response is generated.
- clear_start and an accepted req in the same IDLE cycle: the request completes normally (its response is issued), and CLEAR begins on the same edge. A write made by that request is subsequently zeroed if it targets RAM.
- rst during CLEAR: immediate return to IDLE, no clear_done pulse; RAM is left partially cleared.

## Timing
- Response latency is 1 cycle: for a request accepted at edge N, resp_valid, resp_err and rdata are valid for the cycle following edge N and deassert at edge N+1 unless another request was accepted at edge N+1.
- Throughput in IDLE is one request per cycle, with back-to-back accepts allowed.
- Read-after-write to the same RAM address on consecutive accepts returns the new data.
- Clear sampled at edge E0: ready is low from E0 to E0+2^OFF_W (2^OFF_W cycles). clear_done is high for the single cycle after edge E0+2^OFF_W, and ready returns high in that same cycle.
- All outputs change only on clk edges or on rst assertion; ready is combinational from the state.

## Structure
- Package mem_map_pkg holds:
  - the state enum {IDLE, CLEAR};
  - the region enum {REG_ROM, REG_RAM, REG_UNMAPPED};
  - the constant function fib_word(index, width) used to build the ROM table;
  - the bank-decode function returning the region from the bank index and parameters.
- Sub-module mem_map_ram_bank is instantiated RAM_BANKS times via generate. Interface: clk, we, offset, wdata, rdata (combinational read). The top-level registers rdata.
- ROM is a single elaboration-time constant array in the top level, not a separate sub-module.

## Test plan
Default parameters apply (ADDR_W=8, RAM base 0x40, unmapped from 0x80).
- Reset, then read 0x05 and 0x0F back-to-back -> resp_valid on 2 consecutive cycles, rdata 0x08 then 0xDB (987 mod 256), resp_err=0.
- Write 0x40=0xA5, then read 0x40 on the next cycle -> write response err=0; read response rdata=0xA5.
- Write 0x03=0xFF, then read 0x03 -> first response resp_err=1; read returns 0x03 (unchanged). Read 0x80 -> resp_err=1, rdata=0x00.
- Write 0x4F=0x3C and 0x7F=0x11, pulse clear_start -> ready low exactly 8 cycles, one clear_done pulse. Reads of 0x4F and 0x7F then return 0x00; reads of ROM are unaffected.
- req held high during CLEAR -> no resp_valid until ready returns. A second clear_start mid-clear -> no extension and a single clear_done.
- Assert rst 3 cycles into a clear -> all outputs return to reset values immediately, ready=1, and no clear_done pulse follows.
